// File: rtl/prog_sequencer.sv
// Program sequencer: selectable entry points, relative/absolute branches, halt, and an optional
// return stack for call/return (enabled by defining PROG_SEQ_CALL_STACK_EN).
module prog_sequencer #(
    parameter int PC_W        = 10,
    parameter int OFF_W       = 8,
    parameter int NUM_PROGS   = 4,
    parameter int PROG_STRIDE = 256,
    parameter int STACK_DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         Start,
    input  logic [$clog2(NUM_PROGS)-1:0] ProgSel,
    input  logic                         Stall,
    input  logic                         BranchRelEn,
    input  logic                         ALU_flag,
    input  logic [OFF_W-1:0]             Target,
    input  logic                         BranchAbsEn,
    input  logic [PC_W-1:0]              AbsTarget,
    input  logic                         CallEn,
    input  logic                         RetEn,
    input  logic                         HaltEn,
    output logic [PC_W-1:0]              ProgCtr,
    output logic                         Running,
    output logic                         Done,
    output logic                         StackErr
);

    localparam int SEL_W = $clog2(NUM_PROGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;

    // Entry point is ProgSel*PROG_STRIDE, truncated to the PC width.
    function automatic logic [PC_W-1:0] entry_pc(input logic [SEL_W-1:0] sel);
        logic [63:0] prod;
        prod = 64'(sel) * 64'(PROG_STRIDE);
        return prod[PC_W-1:0];
    endfunction

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] cur);
        return cur + PC_W'(1);
    endfunction

    function automatic logic [PC_W-1:0] rel_target(input logic [PC_W-1:0]        cur,
                                                   input logic signed [OFF_W-1:0] off);
        logic signed [PC_W-1:0] ext;
        ext = PC_W'(off);
        return cur + PC_W'(1) + ext;
    endfunction

`ifdef PROG_SEQ_CALL_STACK_EN
    localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
    localparam int              IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_dec;
    logic             stack_err;
    logic             push;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [PC_W-1:0]  stack [STACK_DEPTH];

    assign sp_dec = sp - SP_W'(1);
    assign wr_idx = IDX_W'(sp);
    assign rd_idx = IDX_W'(sp_dec);

    // Mirrors the RUN priority chain: a call wins only when nothing above it is asserted.
    assign push = !Start && (state == S_RUN) && !Stall && !HaltEn && !RetEn && CallEn
                  && (sp != SP_FULL);

    // Stack entries are plain storage; a reset or Start empties the stack by clearing SP.
    always_ff @(posedge Clk) begin
        if (push) begin
            stack[wr_idx] <= pc_inc(pc);
        end
    end

    assign StackErr = stack_err;
`else
    logic unused_call_ret;
    assign unused_call_ret = CallEn ^ RetEn;
    assign StackErr        = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            pc    <= '0;
`ifdef PROG_SEQ_CALL_STACK_EN
            sp        <= '0;
            stack_err <= 1'b0;
`endif
        end else if (Start) begin
            state <= S_LOAD;
            pc    <= entry_pc(ProgSel);
`ifdef PROG_SEQ_CALL_STACK_EN
            sp        <= '0;
            stack_err <= 1'b0;
`endif
        end else begin
            case (state)
                S_LOAD: state <= S_RUN;
                S_RUN: begin
                    if (!Stall) begin
                        if (HaltEn) begin
                            state <= S_DONE;
`ifdef PROG_SEQ_CALL_STACK_EN
                        end else if (RetEn) begin
                            // Underflow behaves as a plain step and flags the error.
                            if (sp == '0) begin
                                pc        <= pc_inc(pc);
                                stack_err <= 1'b1;
                            end else begin
                                pc <= stack[rd_idx];
                                sp <= sp_dec;
                            end
                        end else if (CallEn) begin
                            pc <= AbsTarget;
                            if (sp == SP_FULL) begin
                                stack_err <= 1'b1;
                            end else begin
                                sp <= sp + SP_W'(1);
                            end
`endif
                        end else if (BranchAbsEn) begin
                            pc <= AbsTarget;
                        end else if (BranchRelEn && ALU_flag) begin
                            pc <= rel_target(pc, Target);
                        end else begin
                            pc <= pc_inc(pc);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ProgCtr = pc;
    assign Running = (state == S_RUN);
    assign Done    = (state == S_DONE);

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: stimulus queues expected {ProgCtr, Running, Done, StackErr}
// per clock; a monitor pops and compares after each rising edge.
module tb_prog_sequencer;

    localparam int PC_W        = 10;
    localparam int OFF_W       = 8;
    localparam int NUM_PROGS   = 4;
    localparam int PROG_STRIDE = 256;
    localparam int STACK_DEPTH = 4;

    logic                         Clk = 1'b0;
    logic                         Reset_n;
    logic                         Start;
    logic [$clog2(NUM_PROGS)-1:0] ProgSel;
    logic                         Stall;
    logic                         BranchRelEn;
    logic                         ALU_flag;
    logic [OFF_W-1:0]             Target;
    logic                         BranchAbsEn;
    logic [PC_W-1:0]              AbsTarget;
    logic                         CallEn;
    logic                         RetEn;
    logic                         HaltEn;
    logic [PC_W-1:0]              ProgCtr;
    logic                         Running;
    logic                         Done;
    logic                         StackErr;

    prog_sequencer #(
        .PC_W(PC_W), .OFF_W(OFF_W), .NUM_PROGS(NUM_PROGS),
        .PROG_STRIDE(PROG_STRIDE), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
        .BranchRelEn(BranchRelEn), .ALU_flag(ALU_flag), .Target(Target),
        .BranchAbsEn(BranchAbsEn), .AbsTarget(AbsTarget), .CallEn(CallEn), .RetEn(RetEn),
        .HaltEn(HaltEn), .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .StackErr(StackErr)
    );

    always #5 Clk = ~Clk;

    int              checks = 0;
    int              errors = 0;
    int              cyc    = 0;
    logic [PC_W-1:0] q_pc [$];
    logic [2:0]      q_fl [$];
    int              q_tgt[$];
    string           q_nm [$];

    // Monitor: every expectation is tagged with the edge count at which it must hold.
    always begin
        @(posedge Clk);
        #1;
        cyc++;
        while (q_tgt.size() > 0 && q_tgt[0] <= cyc) begin
            logic [PC_W-1:0] epc;
            logic [2:0]      efl;
            int              etg;
            string           enm;
            epc = q_pc.pop_front();
            efl = q_fl.pop_front();
            etg = q_tgt.pop_front();
            enm = q_nm.pop_front();
            checks++;
            if (etg != cyc || ProgCtr !== epc || {Running, Done, StackErr} !== efl) begin
                errors++;
                $display("FAIL %s: got pc=%h run/done/err=%b, want pc=%h run/done/err=%b",
                         enm, ProgCtr, {Running, Done, StackErr}, epc, efl);
            end
        end
    end

    task automatic clr();
        Start       = 1'b0;
        ProgSel     = '0;
        Stall       = 1'b0;
        BranchRelEn = 1'b0;
        ALU_flag    = 1'b0;
        Target      = '0;
        BranchAbsEn = 1'b0;
        AbsTarget   = '0;
        CallEn      = 1'b0;
        RetEn       = 1'b0;
        HaltEn      = 1'b0;
    endtask

    // Queue the state expected after the coming rising edge, then advance to the next falling edge.
    task automatic tick(input string nm, input logic [PC_W-1:0] pc,
                        input logic r, input logic d, input logic e);
        q_pc.push_back(pc);
        q_fl.push_back({r, d, e});
        q_tgt.push_back(cyc + 1);
        q_nm.push_back(nm);
        @(negedge Clk);
    endtask

    task automatic jump(input string nm, input logic [PC_W-1:0] dst, input logic e);
        clr();
        BranchAbsEn = 1'b1;
        AbsTarget   = dst;
        tick(nm, dst, 1'b1, 1'b0, e);
        clr();
    endtask

    task automatic call_to(input string nm, input logic [PC_W-1:0] dst, input logic e);
        clr();
        CallEn    = 1'b1;
        AbsTarget = dst;
        tick(nm, dst, 1'b1, 1'b0, e);
        clr();
    endtask

    task automatic ret_to(input string nm, input logic [PC_W-1:0] dst, input logic e);
        clr();
        RetEn = 1'b1;
        tick(nm, dst, 1'b1, 1'b0, e);
        clr();
    endtask

    task automatic start_prog(input string nm, input logic [1:0] sel, input logic [PC_W-1:0] entry);
        clr();
        Start   = 1'b1;
        ProgSel = sel;
        tick(nm, entry, 1'b0, 1'b0, 1'b0);
        clr();
        tick({nm, "_run"}, entry, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        Reset_n = 1'b0;
        @(negedge Clk);
        tick("reset_state", 10'h000, 1'b0, 1'b0, 1'b0);
        Reset_n = 1'b1;
        tick("idle_hold", 10'h000, 1'b0, 1'b0, 1'b0);

        // Start held two cycles stays in LOAD at the entry point, then runs.
        Start   = 1'b1;
        ProgSel = 2'd2;
        tick("start_load", 10'h200, 1'b0, 1'b0, 1'b0);
        tick("start_hold", 10'h200, 1'b0, 1'b0, 1'b0);
        clr();
        tick("load_run", 10'h200, 1'b1, 1'b0, 1'b0);
        tick("run_inc", 10'h201, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-run, checked between clock edges.
        jump("abs_1a3", 10'h1A3, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (ProgCtr !== 10'h000 || Running !== 1'b0 || Done !== 1'b0 || StackErr !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got pc=%h run=%b done=%b err=%b, want pc=000 run=0 done=0 err=0",
                     ProgCtr, Running, Done, StackErr);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        tick("post_reset_idle", 10'h000, 1'b0, 1'b0, 1'b0);

        // Relative branches and wraparound.
        start_prog("start0", 2'd0, 10'h000);
        jump("abs_005", 10'h005, 1'b0);
        BranchRelEn = 1'b1; ALU_flag = 1'b1; Target = 8'hFC;
        tick("rel_neg", 10'h002, 1'b1, 1'b0, 1'b0);
        jump("abs_3ff", 10'h3FF, 1'b0);
        tick("inc_wrap", 10'h000, 1'b1, 1'b0, 1'b0);
        jump("abs_010", 10'h010, 1'b0);
        BranchRelEn = 1'b1; ALU_flag = 1'b0; Target = 8'h7F;
        tick("rel_not_taken", 10'h011, 1'b1, 1'b0, 1'b0);
        ALU_flag = 1'b1;
        tick("rel_pos", 10'h091, 1'b1, 1'b0, 1'b0);
        jump("abs_001", 10'h001, 1'b0);
        BranchRelEn = 1'b1; ALU_flag = 1'b1; Target = 8'hF0;
        tick("rel_wrap_low", 10'h3F2, 1'b1, 1'b0, 1'b0);

        // Stall and action priority.
        jump("abs_040", 10'h040, 1'b0);
        Stall = 1'b1; BranchAbsEn = 1'b1; AbsTarget = 10'h300;
        tick("stall", 10'h040, 1'b1, 1'b0, 1'b0);
        clr();
        HaltEn = 1'b1; CallEn = 1'b1; BranchAbsEn = 1'b1; AbsTarget = 10'h300;
        tick("halt_prio", 10'h040, 1'b0, 1'b1, 1'b0);
        clr();
        BranchAbsEn = 1'b1; AbsTarget = 10'h123;
        tick("done_hold", 10'h040, 1'b0, 1'b1, 1'b0);

`ifdef PROG_SEQ_CALL_STACK_EN
        start_prog("start0b", 2'd0, 10'h000);
        jump("abs_050", 10'h050, 1'b0);
        call_to("call_100", 10'h100, 1'b0);
        ret_to("ret_051", 10'h051, 1'b0);
        call_to("call_n1", 10'h110, 1'b0);
        call_to("call_n2", 10'h120, 1'b0);
        call_to("call_n3", 10'h130, 1'b0);
        call_to("call_n4", 10'h140, 1'b0);
        call_to("call_overflow", 10'h150, 1'b1);
        ret_to("ret_n4", 10'h131, 1'b1);
        ret_to("ret_n3", 10'h121, 1'b1);
        ret_to("ret_n2", 10'h111, 1'b1);
        ret_to("ret_n1", 10'h052, 1'b1);
        ret_to("ret_underflow", 10'h053, 1'b1);
        HaltEn = 1'b1;
        tick("halt_err", 10'h053, 1'b0, 1'b1, 1'b1);
`else
        start_prog("start0b", 2'd0, 10'h000);
        jump("abs_050", 10'h050, 1'b0);
        CallEn = 1'b1; AbsTarget = 10'h100;
        tick("call_disabled", 10'h051, 1'b1, 1'b0, 1'b0);
        clr();
        RetEn = 1'b1;
        tick("ret_disabled", 10'h052, 1'b1, 1'b0, 1'b0);
        clr();
        HaltEn = 1'b1;
        tick("halt", 10'h052, 1'b0, 1'b1, 1'b0);
`endif

        // Start from DONE clears Done and StackErr.
        start_prog("start_from_done", 2'd1, 10'h100);
        tick("final_inc", 10'h101, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 5 && q_tgt.size() > 0; i++) begin
            @(negedge Clk);
        end
        if (q_tgt.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q_tgt.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
